// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory access controller between the core's MEM stage and
// a single-outstanding external memory bus.
//
// A core load/store is turned into one registered bus transaction. The core
// is stalled while the transaction is outstanding. Misaligned accesses are
// flagged and never reach the bus.
//
// Optional feature: define DMEM_TIMEOUT_EN to add an 8-bit REQ-state
// watchdog that aborts a transaction after TIMEOUT_CYC cycles without
// bus_ack. Without the macro the controller waits for bus_ack indefinitely
// and Timeout is tied low.
//
// Parameters
//   TIMEOUT_CYC  REQ cycles without bus_ack before an abort (2..255)
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   MemRead, MemWrite     core access request levels, held until Stall is low
//   Addr, WriteData       core byte address and store data
//   ReadData              registered load data to the write-back mux
//   Stall                 hold PC / current instruction
//   AddrErr               misaligned-access flag
//   Timeout               one-cycle abort flag
//   bus_req/we/addr/wdata registered memory request
//   bus_ack, bus_rdata    memory completion strobe and read data

module dmem_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        Timeout
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("dmem_ctrl: TIMEOUT_CYC must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        access;
    logic        stall_raw;
    logic        addr_err_raw;
`ifdef DMEM_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        read_data_d  = read_data_q;
        stall_raw    = 1'b0;
        addr_err_raw = 1'b0;
        access       = MemRead | MemWrite;
`ifdef DMEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (Addr[1:0] == 2'b00) begin
                        stall_raw   = 1'b1;
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        // A simultaneous read+write request is issued as a write.
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {Addr[31:2], 2'b00};
                        bus_wdata_d = WriteData;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d       = 8'd0;
`endif
                    end else begin
                        addr_err_raw = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall_raw = 1'b1;
                // An ack in the limit cycle wins over the watchdog.
                if (bus_ack) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        read_data_d = bus_rdata;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    timeout_d = 1'b1;
                    if (!bus_we_q) begin
                        read_data_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            read_data_q <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= 8'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            read_data_q <= read_data_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Combinational core-facing flags are forced low while reset is held.
    assign Stall     = stall_raw & ~RST;
    assign AddrErr   = addr_err_raw & ~RST;
    assign ReadData  = read_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
`ifdef DMEM_TIMEOUT_EN
    assign Timeout   = timeout_q;
`else
    assign Timeout   = 1'b0;
`endif

endmodule
